hex_display_driver: RTL and testbench
=====================================

# hex_display_driver

Serial driver for the labkit's 16-character HCMS dot-matrix hex display. Consumes the 64-bit hex word produced by the display controller (16 nibbles, `hex_data[63:60]` = leftmost character) and continuously refreshes the display: power-up reset, one control-word load, then an endless loop of 640-bit dot-data frames. Each frame uses a coherent snapshot of `hex_data` taken at frame start.

## Interface
- `CLK_DIV`, default 14: clk cycles per tick; `disp_clock` half-period is one tick; minimum 2.
- `RESET_TICKS`, default 4: ticks `disp_reset_b` is held low after reset.
- `CTRL_WORD`, default 8'h7F: control word 0 (bit7=0, bit6 normal mode, bits5:4 peak current, bits3:0 brightness).
---
- `clk` in 1: system clock. Single clock domain.
- `reset` in 1: synchronous, active-high.
- `hex_data` in 64: 16 hex digits to display.
- `disp_blank` out 1: 1 blanks the display.
- `disp_clock` out 1: serial clock; the display samples on the rising edge.
- `disp_rs` out 1: register select, 1 = control, 0 = dot.
- `disp_ce_b` out 1: chip enable, active low; the rising edge latches.
- `disp_reset_b` out 1: display reset, active low.
- `disp_data_out` out 1: serial data, MSB first.
- `frame_done` out 1: one-cycle pulse at the end of each dot frame.

## Operation
- **Tick.** Divider counts 0..CLK_DIV-1. `tick` = 1 for one cycle when the count is CLK_DIV-1. The divider resets to 0 on `reset`. All FSM and pin changes occur only on tick cycles.
- **S_RESET.** `disp_reset_b`=0, `disp_blank`=1, `disp_ce_b`=1. After RESET_TICKS ticks, go to S_CTRL_LOAD.
- **S_CTRL_LOAD.**
  - On entry: `disp_rs`=1, `disp_ce_b`=0, `disp_reset_b`=1, `disp_blank`=0, `disp_data_out`=CTRL_WORD[7].
  - Each tick toggles `disp_clock`.
  - On each 1→0 transition, present the next bit.
  - After the falling edge that follows bit 0, go to S_CTRL_LATCH.
- **S_CTRL_LATCH.** `disp_ce_b`=1 for 2 ticks. Then snapshot `hex_data` and go to S_DOT_LOAD.
- **S_DOT_LOAD.**
  - `disp_rs`=0, `disp_ce_b`=0, same shift discipline as S_CTRL_LOAD.
  - Shift 640 bits in this order: character 15 down to 0; within a character, columns 0..4 (left to right); within a column, bits 7 down to 0.
  - Column byte = `hex_font_rom(nibble, col)`; bit 7 is always 0.
  - A 10-bit counter covers bits 0..639; its terminal count is 639.
- **S_DOT_LATCH.** `disp_ce_b`=1 for 2 ticks. On exit: `frame_done`=1 for one clk cycle, re-snapshot `hex_data` in the same cycle, return to S_DOT_LOAD.
- **Snapshot rule.** `hex_data` changes during a frame have no effect until the next snapshot.
- **Idle pins.** `disp_clock` is 0 in every state other than the two LOAD states. `disp_data_out` is 0 in latch states.
- **Reset mid-operation.** On the next cycle, all outputs take their reset values, the divider and counters clear, and the FSM restarts at S_RESET, including the control-word load.

## Timing
- **Reset values:**
  - `disp_reset_b`=0, `disp_blank`=1, `disp_ce_b`=1
  - `disp_rs`=0, `disp_clock`=0, `disp_data_out`=0
  - `frame_done`=0
- **Bit period.** 2 ticks = 2·CLK_DIV clk cycles. Data is stable one tick before each rising edge of `disp_clock`.
- **Control phase.** 8·2 + 2 = 18 ticks.
- **Dot frame.** 640·2 + 2 = 1282 ticks, so `frame_done` has period 1282·CLK_DIV cycles.
- **First `frame_done`.** (RESET_TICKS + 18 + 1282)·CLK_DIV cycles after `reset` deasserts, ±1 cycle; the bench checks the exact value against the RTL's registered pipeline.
- **Registered outputs.** All outputs are registers; no combinational path from `hex_data` to any pin.

## Structure
- **Shared include `display_defs.vh`:**
  - NUM_CHARS=16, COLS_PER_CHAR=5, BITS_PER_COL=8, DOT_BITS=640
  - FSM state encodings (S_RESET, S_CTRL_LOAD, S_CTRL_LATCH, S_DOT_LOAD, S_DOT_LATCH)
- **Sub-module `hex_font_rom`.** Combinational; inputs 4-bit nibble and 3-bit column, output 8-bit column byte. Includes:
  - '0' = 3E,51,49,45,3E
  - '8' = 36,49,49,49,36
  - 'F' = 7F,09,09,09,01
- **Top-level contents.** Divider, FSM, bit/character counters, snapshot register, output registers.

## Test plan
- **Reset values.** CLK_DIV=2; hold `reset` 3 cycles → all outputs at reset values; `disp_reset_b` rises after 4 ticks = 8 cycles.
- **Control load.** CTRL_WORD=8'hA5 → with `disp_rs`=1 and `disp_ce_b`=0, bits sampled on rising `disp_clock` are 1,0,1,0,0,1,0,1; then `disp_ce_b` rises.
- **Digit '0'.** `hex_data`=64'h0 → first 40 dot bits sampled = 3E,51,49,45,3E MSB-first, i.e. first byte 0,0,1,1,1,1,1,0; 640 rising edges per frame.
- **Digits 'F' and '8'.** `hex_data`=64'hF000_0000_0000_0008 → first 40 bits decode to 7F,09,09,09,01; last 40 bits decode to 36,49,49,49,36.
- **Snapshot coherence.** Change `hex_data` from 0 to all-F at dot bit 100 → the rest of the frame still shows '0'; the next frame shows 'F'; consecutive `frame_done` pulses are exactly 2564 cycles apart (CLK_DIV=2).
- **Reset mid-frame.** Assert `reset` at dot bit 300 → next cycle outputs at reset values; the sequence restarts with S_RESET and a control load before any dot data.

Source files
------------

// File: rtl/hex_display_driver_pkg.sv
// Shared constants and FSM encoding for the HCMS hex display driver.
package hex_display_driver_pkg;

    localparam int NUM_CHARS     = 16;
    localparam int COLS_PER_CHAR = 5;
    localparam int BITS_PER_COL  = 8;
    localparam int DOT_BITS      = NUM_CHARS * COLS_PER_CHAR * BITS_PER_COL;
    localparam int LATCH_TICKS   = 2;

    typedef enum logic [2:0] {
        S_RESET      = 3'd0,
        S_CTRL_LOAD  = 3'd1,
        S_CTRL_LATCH = 3'd2,
        S_DOT_LOAD   = 3'd3,
        S_DOT_LATCH  = 3'd4
    } state_e;

endpackage

// File: rtl/hex_display_driver_if.sv
// Display-side bundle: hex word in, serial display pins and frame pulse out.
interface hex_display_driver_if;
    import hex_display_driver_pkg::*;

    logic [63:0] hex_data;
    logic        disp_blank;
    logic        disp_clock;
    logic        disp_rs;
    logic        disp_ce_b;
    logic        disp_reset_b;
    logic        disp_data_out;
    logic        frame_done;
    state_e      dbg_state;

    // The display samples disp_data_out on rising disp_clock while disp_ce_b is low;
    // the rising edge of disp_ce_b latches the shifted word.
    modport master (
        input  hex_data,
        output disp_blank, disp_clock, disp_rs, disp_ce_b,
        output disp_reset_b, disp_data_out, frame_done, dbg_state
    );

    modport slave (
        output hex_data,
        input  disp_blank, disp_clock, disp_rs, disp_ce_b,
        input  disp_reset_b, disp_data_out, frame_done, dbg_state
    );

endinterface

// File: rtl/hex_display_driver_font_rom.sv
// 5x7 hex glyph ROM: one 8-bit column byte per (nibble, column), bit 7 unused.
module hex_font_rom (
    input  logic [3:0] i_nibble,
    input  logic [2:0] i_col,
    output logic [7:0] o_byte
);

    logic [39:0] w_glyph;

    // Column 0 occupies the top byte of each glyph word.
    always_comb begin
        w_glyph = 40'h00_00_00_00_00;
        case (i_nibble)
            4'h0: w_glyph = 40'h3E_51_49_45_3E;
            4'h1: w_glyph = 40'h00_42_7F_40_00;
            4'h2: w_glyph = 40'h42_61_51_49_46;
            4'h3: w_glyph = 40'h21_41_45_4B_31;
            4'h4: w_glyph = 40'h18_14_12_7F_10;
            4'h5: w_glyph = 40'h27_45_45_45_39;
            4'h6: w_glyph = 40'h3C_4A_49_49_30;
            4'h7: w_glyph = 40'h01_71_09_05_03;
            4'h8: w_glyph = 40'h36_49_49_49_36;
            4'h9: w_glyph = 40'h06_49_49_29_1E;
            4'hA: w_glyph = 40'h7E_11_11_11_7E;
            4'hB: w_glyph = 40'h7F_49_49_49_36;
            4'hC: w_glyph = 40'h3E_41_41_41_22;
            4'hD: w_glyph = 40'h7F_41_41_22_1C;
            4'hE: w_glyph = 40'h7F_49_49_49_41;
            4'hF: w_glyph = 40'h7F_09_09_09_01;
            default: w_glyph = 40'h00_00_00_00_00;
        endcase
    end

    always_comb begin
        o_byte = 8'h00;
        case (i_col)
            3'd0:    o_byte = w_glyph[39:32];
            3'd1:    o_byte = w_glyph[31:24];
            3'd2:    o_byte = w_glyph[23:16];
            3'd3:    o_byte = w_glyph[15:8];
            3'd4:    o_byte = w_glyph[7:0];
            default: o_byte = 8'h00;
        endcase
    end

endmodule

// File: rtl/hex_display_driver.sv
// Continuously refreshes a 16-character HCMS display from a 64-bit hex word:
// display reset, one control-word load, then endless 640-bit dot frames.
module hex_display_driver
    import hex_display_driver_pkg::*;
#(
    parameter int          CLK_DIV     = 14,
    parameter int          RESET_TICKS = 4,
    parameter logic [7:0]  CTRL_WORD   = 8'h7F
) (
    input  logic                 clk,
    input  logic                 reset,
    hex_display_driver_if.master bus
);

    localparam int          DIV_W      = $clog2(CLK_DIV);
    localparam logic [15:0] RESET_LAST = 16'(RESET_TICKS - 1);
    localparam logic [15:0] LATCH_LAST = 16'(LATCH_TICKS - 1);
    localparam logic [9:0]  DOT_LAST   = 10'(DOT_BITS - 1);
    localparam logic [2:0]  COL_LAST   = 3'(COLS_PER_CHAR - 1);
    localparam logic [2:0]  BIT_FIRST  = 3'(BITS_PER_COL - 1);
    localparam logic [3:0]  CHAR_FIRST = 4'(NUM_CHARS - 1);

    logic [DIV_W-1:0] r_div;
    state_e           r_state, w_state_nx;
    logic [15:0]      r_tick_cnt, w_tick_cnt_nx;
    logic [9:0]       r_bit_cnt, w_bit_cnt_nx;
    logic [3:0]       r_char, w_char_nx;
    logic [2:0]       r_col, w_col_nx;
    logic [2:0]       r_bit, w_bit_nx;
    logic [63:0]      r_snap, w_snap_nx;
    logic             r_blank, w_blank_nx;
    logic             r_clock, w_clock_nx;
    logic             r_rs, w_rs_nx;
    logic             r_ce_b, w_ce_b_nx;
    logic             r_reset_b, w_reset_b_nx;
    logic             r_data, w_data_nx;
    logic             r_frame_done, w_frame_done_nx;

    logic             w_tick;
    logic             w_dot_entry;
    logic [2:0]       w_adv_bit, w_adv_col;
    logic [3:0]       w_adv_char;
    logic [3:0]       w_font_nibble;
    logic [2:0]       w_font_col, w_font_bit;
    logic [7:0]       w_font_byte;

    assign w_tick = (r_div == DIV_W'(CLK_DIV - 1));

    // Leaving either latch state starts a dot frame; the first bit comes from the
    // live word, which is the same value being captured into the snapshot.
    assign w_dot_entry = w_tick && (r_tick_cnt == LATCH_LAST) &&
                         ((r_state == S_CTRL_LATCH) || (r_state == S_DOT_LATCH));

    // Position of the next bit: bit 7..0 within column 0..4 within char 15..0.
    assign w_adv_bit  = (r_bit == 3'd0) ? BIT_FIRST : (r_bit - 3'd1);
    assign w_adv_col  = (r_bit != 3'd0) ? r_col :
                        ((r_col == COL_LAST) ? 3'd0 : (r_col + 3'd1));
    assign w_adv_char = ((r_bit == 3'd0) && (r_col == COL_LAST)) ? (r_char - 4'd1) : r_char;

    assign w_font_nibble = w_dot_entry ? bus.hex_data[63:60] : r_snap[{w_adv_char, 2'b00} +: 4];
    assign w_font_col    = w_dot_entry ? 3'd0 : w_adv_col;
    assign w_font_bit    = w_dot_entry ? BIT_FIRST : w_adv_bit;

    hex_font_rom u_font_rom (
        .i_nibble (w_font_nibble),
        .i_col    (w_font_col),
        .o_byte   (w_font_byte)
    );

    always_comb begin
        w_state_nx      = r_state;
        w_tick_cnt_nx   = r_tick_cnt;
        w_bit_cnt_nx    = r_bit_cnt;
        w_char_nx       = r_char;
        w_col_nx        = r_col;
        w_bit_nx        = r_bit;
        w_snap_nx       = r_snap;
        w_blank_nx      = r_blank;
        w_clock_nx      = r_clock;
        w_rs_nx         = r_rs;
        w_ce_b_nx       = r_ce_b;
        w_reset_b_nx    = r_reset_b;
        w_data_nx       = r_data;
        w_frame_done_nx = 1'b0;

        if (w_tick) begin
            case (r_state)
                S_RESET: begin
                    if (r_tick_cnt == RESET_LAST) begin
                        w_state_nx    = S_CTRL_LOAD;
                        w_tick_cnt_nx = 16'd0;
                        w_bit_nx      = BIT_FIRST;
                        w_rs_nx       = 1'b1;
                        w_ce_b_nx     = 1'b0;
                        w_reset_b_nx  = 1'b1;
                        w_blank_nx    = 1'b0;
                        w_data_nx     = CTRL_WORD[7];
                    end else begin
                        w_tick_cnt_nx = r_tick_cnt + 16'd1;
                    end
                end

                S_CTRL_LOAD: begin
                    if (!r_clock) begin
                        w_clock_nx = 1'b1;
                    end else begin
                        w_clock_nx = 1'b0;
                        if (r_bit == 3'd0) begin
                            w_state_nx    = S_CTRL_LATCH;
                            w_tick_cnt_nx = 16'd0;
                            w_ce_b_nx     = 1'b1;
                            w_data_nx     = 1'b0;
                        end else begin
                            w_bit_nx  = w_adv_bit;
                            w_data_nx = CTRL_WORD[w_adv_bit];
                        end
                    end
                end

                S_CTRL_LATCH, S_DOT_LATCH: begin
                    if (r_tick_cnt == LATCH_LAST) begin
                        w_state_nx      = S_DOT_LOAD;
                        w_tick_cnt_nx   = 16'd0;
                        w_bit_cnt_nx    = 10'd0;
                        w_char_nx       = CHAR_FIRST;
                        w_col_nx        = 3'd0;
                        w_bit_nx        = BIT_FIRST;
                        w_snap_nx       = bus.hex_data;
                        w_rs_nx         = 1'b0;
                        w_ce_b_nx       = 1'b0;
                        w_data_nx       = w_font_byte[w_font_bit];
                        w_frame_done_nx = (r_state == S_DOT_LATCH);
                    end else begin
                        w_tick_cnt_nx = r_tick_cnt + 16'd1;
                    end
                end

                S_DOT_LOAD: begin
                    if (!r_clock) begin
                        w_clock_nx = 1'b1;
                    end else begin
                        w_clock_nx = 1'b0;
                        if (r_bit_cnt == DOT_LAST) begin
                            w_state_nx    = S_DOT_LATCH;
                            w_tick_cnt_nx = 16'd0;
                            w_ce_b_nx     = 1'b1;
                            w_data_nx     = 1'b0;
                        end else begin
                            w_bit_cnt_nx = r_bit_cnt + 10'd1;
                            w_char_nx    = w_adv_char;
                            w_col_nx     = w_adv_col;
                            w_bit_nx     = w_adv_bit;
                            w_data_nx    = w_font_byte[w_font_bit];
                        end
                    end
                end

                default: begin
                    w_state_nx    = S_RESET;
                    w_tick_cnt_nx = 16'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div        <= '0;
            r_state      <= S_RESET;
            r_tick_cnt   <= 16'd0;
            r_bit_cnt    <= 10'd0;
            r_char       <= CHAR_FIRST;
            r_col        <= 3'd0;
            r_bit        <= BIT_FIRST;
            r_snap       <= 64'd0;
            r_blank      <= 1'b1;
            r_clock      <= 1'b0;
            r_rs         <= 1'b0;
            r_ce_b       <= 1'b1;
            r_reset_b    <= 1'b0;
            r_data       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_div        <= w_tick ? '0 : (r_div + DIV_W'(1));
            r_state      <= w_state_nx;
            r_tick_cnt   <= w_tick_cnt_nx;
            r_bit_cnt    <= w_bit_cnt_nx;
            r_char       <= w_char_nx;
            r_col        <= w_col_nx;
            r_bit        <= w_bit_nx;
            r_snap       <= w_snap_nx;
            r_blank      <= w_blank_nx;
            r_clock      <= w_clock_nx;
            r_rs         <= w_rs_nx;
            r_ce_b       <= w_ce_b_nx;
            r_reset_b    <= w_reset_b_nx;
            r_data       <= w_data_nx;
            r_frame_done <= w_frame_done_nx;
        end
    end

    assign bus.disp_blank    = r_blank;
    assign bus.disp_clock    = r_clock;
    assign bus.disp_rs       = r_rs;
    assign bus.disp_ce_b     = r_ce_b;
    assign bus.disp_reset_b  = r_reset_b;
    assign bus.disp_data_out = r_data;
    assign bus.frame_done    = r_frame_done;
    assign bus.dbg_state     = r_state;

endmodule

// File: tb/tb_hex_display_driver.sv
// Bench for hex_display_driver: decodes the serial pin stream and checks
// reset behaviour, control load, glyph data, snapshot coherence and mid-frame reset.
module tb_hex_display_driver;
    import hex_display_driver_pkg::*;

    localparam logic [39:0] G0 = 40'h3E_51_49_45_3E;
    localparam logic [39:0] G8 = 40'h36_49_49_49_36;
    localparam logic [39:0] GF = 40'h7F_09_09_09_01;

    typedef struct {
        int          pos;
        logic [39:0] glyph;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;

    int n_checks = 0;
    int n_fail = 0;
    int t_rel = 0;

    logic [2:0] cap_q[$];
    int         fd_cyc_q[$];
    int         fd_edges_q[$];
    int         ce_rise_q[$];
    int         rstb_rise_q[$];
    int         edges_since = 0;
    logic       prev_clock = 1'b0;
    logic       prev_ce = 1'b1;
    logic       prev_rstb = 1'b0;

    vec_t vecs[16];

    hex_display_driver_if bus ();

    hex_display_driver #(
        .CLK_DIV     (2),
        .RESET_TICKS (4),
        .CTRL_WORD   (8'hA5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pin decoder: sample on the falling system edge, away from pin updates.
    always @(negedge clk) begin
        if (bus.disp_clock === 1'b1 && prev_clock === 1'b0) begin
            cap_q.push_back({bus.disp_rs, bus.disp_ce_b, bus.disp_data_out});
            edges_since = edges_since + 1;
        end
        if (bus.frame_done === 1'b1) begin
            fd_cyc_q.push_back(cyc);
            fd_edges_q.push_back(edges_since);
            edges_since = 0;
        end
        if (bus.disp_ce_b === 1'b1 && prev_ce === 1'b0) ce_rise_q.push_back(cyc);
        if (bus.disp_reset_b === 1'b1 && prev_rstb === 1'b0) rstb_rise_q.push_back(cyc);
        prev_clock = bus.disp_clock;
        prev_ce    = bus.disp_ce_b;
        prev_rstb  = bus.disp_reset_b;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_monitor();
        cap_q.delete();
        fd_cyc_q.delete();
        fd_edges_q.delete();
        ce_rise_q.delete();
        rstb_rise_q.delete();
        edges_since = 0;
    endtask

    task automatic wait_caps(input int n, input int budget);
        int k;
        k = 0;
        while (cap_q.size() < n && k < budget) begin
            step();
            k++;
        end
        check("wait_caps", 64'(cap_q.size() >= n), 64'd1);
    endtask

    task automatic wait_fd(input int n, input int budget);
        int k;
        k = 0;
        while (fd_cyc_q.size() < n && k < budget) begin
            step();
            k++;
        end
        check("wait_frame_done", 64'(fd_cyc_q.size() >= n), 64'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_reset_b"}, 64'(bus.disp_reset_b), 64'd0);
        check({tag, "_blank"}, 64'(bus.disp_blank), 64'd1);
        check({tag, "_ce_b"}, 64'(bus.disp_ce_b), 64'd1);
        check({tag, "_rs"}, 64'(bus.disp_rs), 64'd0);
        check({tag, "_clock"}, 64'(bus.disp_clock), 64'd0);
        check({tag, "_data"}, 64'(bus.disp_data_out), 64'd0);
        check({tag, "_frame_done"}, 64'(bus.frame_done), 64'd0);
        check({tag, "_state"}, 64'(bus.dbg_state), 64'(S_RESET));
    endtask

    task automatic check_ctrl(input string tag);
        logic [7:0] bits;
        int bad;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            bits[7-i] = cap_q[i][0];
            if (cap_q[i][2:1] !== 2'b10) bad++;
        end
        check({tag, "_ctrl_bits"}, 64'(bits), 64'hA5);
        check({tag, "_ctrl_rs_ce"}, 64'(bad), 64'd0);
        check({tag, "_first_dot_rs"}, 64'(cap_q[8][2]), 64'd0);
    endtask

    // Glyph at transmit position pos (0 = leftmost character) of dot frame f (1-based).
    function automatic logic [39:0] glyph_at(input int f, input int pos);
        logic [39:0] g;
        int base;
        base = 8 + 640 * (f - 1) + 40 * pos;
        for (int j = 0; j < 40; j++)
            g[39-j] = (base + j < cap_q.size()) ? cap_q[base+j][0] : 1'bx;
        return g;
    endfunction

    function automatic int frame_pin_errors(input int f);
        int bad;
        int base;
        bad = 0;
        base = 8 + 640 * (f - 1);
        for (int j = 0; j < 640; j++)
            if (base + j >= cap_q.size() || cap_q[base+j][2:1] !== 2'b00) bad++;
        return bad;
    endfunction

    initial begin
        vecs[0]  = '{0,  40'h3E_51_49_45_3E};
        vecs[1]  = '{1,  40'h00_42_7F_40_00};
        vecs[2]  = '{2,  40'h42_61_51_49_46};
        vecs[3]  = '{3,  40'h21_41_45_4B_31};
        vecs[4]  = '{4,  40'h18_14_12_7F_10};
        vecs[5]  = '{5,  40'h27_45_45_45_39};
        vecs[6]  = '{6,  40'h3C_4A_49_49_30};
        vecs[7]  = '{7,  40'h01_71_09_05_03};
        vecs[8]  = '{8,  40'h36_49_49_49_36};
        vecs[9]  = '{9,  40'h06_49_49_29_1E};
        vecs[10] = '{10, 40'h7E_11_11_11_7E};
        vecs[11] = '{11, 40'h7F_49_49_49_36};
        vecs[12] = '{12, 40'h3E_41_41_41_22};
        vecs[13] = '{13, 40'h7F_41_41_22_1C};
        vecs[14] = '{14, 40'h7F_49_49_49_41};
        vecs[15] = '{15, 40'h7F_09_09_09_01};

        bus.hex_data = 64'h0;
        reset = 1'b1;
        repeat (3) step();
        check_reset_vals("por");

        reset = 1'b0;
        t_rel = cyc;
        clear_monitor();

        // Change the word 100 bits into frame 1; it must not show until frame 2.
        wait_caps(8 + 100, 1000);
        bus.hex_data = 64'hFFFF_FFFF_FFFF_FFFF;

        wait_fd(1, 4000);
        check("reset_b_rise", 64'(rstb_rise_q[0] - t_rel), 64'd8);
        check("ctrl_ce_rise", 64'(ce_rise_q[0] - t_rel), 64'd40);
        check("first_frame_done", 64'(fd_cyc_q[0] - t_rel), 64'd2608);
        check("edges_to_fd1", 64'(fd_edges_q[0]), 64'd648);
        check_ctrl("boot");
        check("f1_first_glyph", 64'(glyph_at(1, 0)), 64'(G0));
        begin
            int bad;
            bad = 0;
            for (int p = 0; p < 16; p++) if (glyph_at(1, p) !== G0) bad++;
            check("f1_all_zero_glyphs", 64'(bad), 64'd0);
        end
        check("f1_pins", 64'(frame_pin_errors(1)), 64'd0);
        bus.hex_data = 64'hF000_0000_0000_0008;

        wait_fd(2, 3000);
        check("fd_period", 64'(fd_cyc_q[1] - fd_cyc_q[0]), 64'd2564);
        check("edges_per_frame", 64'(fd_edges_q[1]), 64'd640);
        begin
            int bad;
            bad = 0;
            for (int p = 0; p < 16; p++) if (glyph_at(2, p) !== GF) bad++;
            check("f2_all_f_glyphs", 64'(bad), 64'd0);
        end
        bus.hex_data = 64'h0123_4567_89AB_CDEF;

        wait_fd(3, 3000);
        check("f3_first_F", 64'(glyph_at(3, 0)), 64'(GF));
        check("f3_last_8", 64'(glyph_at(3, 15)), 64'(G8));
        check("f3_middle_0", 64'(glyph_at(3, 7)), 64'(G0));
        check("fd_period_2", 64'(fd_cyc_q[2] - fd_cyc_q[1]), 64'd2564);

        wait_fd(4, 3000);
        for (int i = 0; i < 16; i++)
            check($sformatf("f4_glyph_pos%0d", vecs[i].pos),
                  64'(glyph_at(4, vecs[i].pos)), 64'(vecs[i].glyph));
        check("f4_pins", 64'(frame_pin_errors(4)), 64'd0);

        // Reset 300 bits into frame 5: restart from display reset and control load.
        wait_caps(8 + 640 * 4 + 300, 2000);
        reset = 1'b1;
        step();
        check_reset_vals("midrst");
        repeat (2) step();
        reset = 1'b0;
        t_rel = cyc;
        clear_monitor();

        wait_caps(9, 500);
        check("re_reset_b_rise", 64'(rstb_rise_q[0] - t_rel), 64'd8);
        check("re_ctrl_ce_rise", 64'(ce_rise_q[0] - t_rel), 64'd40);
        check_ctrl("restart");
        wait_fd(1, 4000);
        check("re_first_frame_done", 64'(fd_cyc_q[0] - t_rel), 64'd2608);
        check("re_edges_to_fd1", 64'(fd_edges_q[0]), 64'd648);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
